uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing controller for the UART receiver. It detects the falling edge of a frame on the synchronised serial line and owns the oversampling edge counter and the bit counter. It steps the start, data, parity and stop phases, driving the enables of the sampler, start/parity/stop checkers and deserializer. It qualifies each completed frame with a single-cycle `data_valid` pulse.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `CLK`  in  1: receiver oversampling clock.
- `RST`  in  1: asynchronous reset, active-high.
- `RX_IN`  in  1: serial line, already synchronised to `CLK`; idle high.
- `prescale`  in  6: oversampling ratio; 8, 16 or 32; any other value is treated as 8.
- `PAR_EN`  in  1: a parity bit follows the data bits.
- `strt_glitch`  in  1: start-check result; 1 means a false start.
- `par_err`  in  1: parity-check result.
- `stp_err`  in  1: stop-check result.
- `edge_cnt`  out  5: oversampling edge index within the current bit, 0..P-1.
- `bit_cnt`  out  4: bit index within the frame (0 = start, 1..DATA_WIDTH = data, DATA_WIDTH+1 = parity).
- `dat_samp_en`  out  1: sampler enable.
- `strt_chk_en`  out  1: start-check enable.
- `deser_en`  out  1: deserializer shift strobe.
- `par_chk_en`  out  1: parity-check enable.
- `stp_chk_en`  out  1: stop-check enable.
- `data_valid`  out  1: frame received without error; one-cycle pulse.

## Operation
- **Prescale latch.**
  - P is the effective prescale, latched on IDLE->START.
  - A `prescale` change during a frame has no effect until the next frame.
- **Counters.**
  - Outside IDLE, `edge_cnt` increments every cycle.
  - At `edge_cnt == P-1` ("bit end") `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - In IDLE both counters are held at 0.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** `RX_IN == 0` -> START with `edge_cnt = 0` and `bit_cnt = 0`.
- **START.**
  - Asserts `strt_chk_en` and `dat_samp_en`.
  - At bit end: `strt_glitch == 1` -> IDLE with counters cleared; otherwise -> DATA with `bit_cnt = 1`.
- **DATA.**
  - Asserts `dat_samp_en`.
  - Asserts `deser_en` for exactly the bit-end cycle of each data bit.
  - At bit end with `bit_cnt == DATA_WIDTH`: -> PARITY if `PAR_EN`, else -> STOP.
- **PARITY.**
  - Asserts `dat_samp_en` and `par_chk_en`.
  - At bit end, `par_err` is captured into an internal error flag, then -> STOP.
- **STOP.**
  - Asserts `dat_samp_en` and `stp_chk_en`.
  - At bit end, `stp_err` is evaluated together with the parity error flag.
  - Next state at that bit end: `RX_IN == 0` -> START directly, supporting back-to-back frames with counters reset to 0; otherwise -> IDLE.
- **Error flag.** Cleared on entry to START.
- **`PAR_EN` latch.** `PAR_EN` is latched on IDLE->START, like `prescale`.
- **Output decode.** All enables are decoded from the state and are 0 in IDLE.

## Timing
- **Reset.**
  - Asynchronous: state IDLE, `edge_cnt = 0`, `bit_cnt = 0`, error flag 0, all enables 0, `data_valid = 0`.
  - A reset mid-frame abandons the frame with no `data_valid`.
- **Frame length** from the first START cycle to the last STOP cycle:
  - (DATA_WIDTH+2)·P cycles without parity.
  - (DATA_WIDTH+3)·P cycles with parity.
- **`data_valid`.**
  - Registered; high for exactly one cycle, the cycle after the STOP bit end.
  - Requires `stp_err == 0` and a clear parity error flag at that bit end.
  - It overlaps the first cycle of a following START when frames are back-to-back.
- **False start.** Returns to IDLE at the START bit end; no `deser_en`, no `data_valid`.
  - If `RX_IN` is still 0 in the following IDLE cycle, START is re-entered.
- **Checker contract.** `strt_glitch`, `par_err` and `stp_err` are read only at bit end. The checkers must present a stable result by that cycle.

## Test plan
- **Clean frame.** P=8, `PAR_EN=0`, byte 0xA5.
  - Exactly 8 `deser_en` pulses, at cycles 15, 23, …, 71 after START entry.
  - `data_valid` high for one cycle at cycle 80.
- **Parity.** P=16, `PAR_EN=1`, correct parity, then a second frame with `par_err=1` at parity bit end.
  - First frame: `data_valid` pulse after 11·16 cycles.
  - Second frame: no pulse; FSM returns to IDLE.
- **False start.** `RX_IN` low for 3 cycles, `strt_glitch=1` at bit end.
  - Returns to IDLE at cycle 7 with counters 0.
  - No `dat_samp_en` activity after that; no `deser_en`.
- **Back-to-back.** Two frames with the start bit immediately after stop.
  - STOP->START without an IDLE cycle.
  - Two `data_valid` pulses spaced (DATA_WIDTH+2)·P cycles apart.
- **Stop error.** `stp_err=1` at the STOP bit end -> no `data_valid`.
- **Prescale and reset.**
  - `prescale` changed 8->32 mid-frame: frame timing stays at 8.
  - Illegal `prescale` 5 behaves as 8.
  - `RST` asserted mid-DATA: all outputs 0 immediately; a clean frame afterwards receives correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: frame detection, oversampling/bit counters,
// phase enables for the sampler and checkers, and the data_valid qualifier.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] prescale,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    state_t     state;
    logic [5:0] p_lat;
    logic       par_lat;
    logic       par_flag;
    logic [5:0] eff_prescale;
    logic       bit_end;

    // Only 16 and 32 are honoured; every other ratio falls back to 8.
    always_comb begin
        eff_prescale = 6'd8;
        case (prescale)
            6'd16:   eff_prescale = 6'd16;
            6'd32:   eff_prescale = 6'd32;
            default: eff_prescale = 6'd8;
        endcase
    end

    assign bit_end = ({1'b0, edge_cnt} == (p_lat - 6'd1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= 5'd0;
            bit_cnt    <= 4'd0;
            p_lat      <= 6'd8;
            par_lat    <= 1'b0;
            par_flag   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= 5'd0;
                bit_cnt  <= 4'd0;
                if (!RX_IN) begin
                    state    <= START;
                    p_lat    <= eff_prescale;
                    par_lat  <= PAR_EN;
                    par_flag <= 1'b0;
                end
            end else begin
                if (bit_end) begin
                    edge_cnt <= 5'd0;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    edge_cnt <= edge_cnt + 5'd1;
                end
                if (bit_end) begin
                    case (state)
                        START: begin
                            if (strt_glitch) begin
                                state   <= IDLE;
                                bit_cnt <= 4'd0;
                            end else begin
                                state <= DATA;
                            end
                        end
                        DATA: begin
                            if (bit_cnt == LAST_DATA)
                                state <= par_lat ? PARITY : STOP;
                        end
                        PARITY: begin
                            par_flag <= par_err;
                            state    <= STOP;
                        end
                        STOP: begin
                            data_valid <= !stp_err && !par_flag;
                            bit_cnt    <= 4'd0;
                            // A low line at the stop bit end is the next start bit.
                            if (!RX_IN) begin
                                state    <= START;
                                p_lat    <= eff_prescale;
                                par_lat  <= PAR_EN;
                                par_flag <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign dat_samp_en = (state != IDLE);
    assign strt_chk_en = (state == START);
    assign deser_en    = (state == DATA) && bit_end;
    assign par_chk_en  = (state == PARITY);
    assign stp_chk_en  = (state == STOP);
    assign state_dbg   = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames against an event-list model of the receive sequencer.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int got_q[$];
    int dv_t[$];

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(clk), .RST(rst), .RX_IN(rx_in), .prescale(prescale), .PAR_EN(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Events: 1 = deser strobe (cycle, bit, edge), 2 = data_valid, 3 = start entry.
    function automatic int ev(input int kind, input int c, input int b, input int e);
        return (kind << 28) | (c << 10) | (b << 5) | e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (deser_en) got_q.push_back(ev(1, cyc, int'(bit_cnt), int'(edge_cnt)));
            if (data_valid) begin
                got_q.push_back(ev(2, cyc, 0, 0));
                dv_t.push_back(cyc);
            end
            if (strt_chk_en && edge_cnt == 5'd0) got_q.push_back(ev(3, cyc, 0, 0));
        end
    end

    function automatic int outs();
        return int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
                     par_chk_en, stp_chk_en, data_valid});
    endfunction

    function automatic int eff_p(input logic [5:0] pre);
        return (pre == 6'd16 || pre == 6'd32) ? int'(pre) : 8;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic flush(input string tag);
        int n;
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        got_q.sort();
        exp_q.sort();
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        dv_t.delete();
        @(negedge clk);
    endtask

    // Drives one frame on the line (called on a negedge) and predicts its events.
    task automatic send_frame(input logic [8:0] data, input int chg_at, input logic [5:0] chg_val);
        int   p, s, nb, l;
        logic par;
        logic bits [12];
        p   = eff_p(prescale);
        par = par_en;
        s   = cyc + 1;
        nb  = DW + 2 + (par ? 1 : 0);
        l   = nb * p;
        exp_q.push_back(ev(3, s, 0, 0));
        for (int i = 0; i < DW; i++) exp_q.push_back(ev(1, s + p * (i + 1) + p - 1, i + 1, p - 1));
        if (!stp_err && !(par && par_err)) exp_q.push_back(ev(2, s + l, 0, 0));
        for (int i = 0; i < 12; i++) bits[i] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i + 1] = data[i];
        if (par) bits[DW + 1] = ^data[DW-1:0];
        for (int k = 0; k < l; k++) begin
            rx_in = bits[k / p];
            if (k == chg_at) prescale = chg_val;
            @(negedge clk);
        end
    endtask

    initial begin
        int s, act, gap, sp;
        @(negedge clk);
        #1 chk("reset_outputs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        prescale = 6'd8; par_en = 1'b0;
        send_frame(9'h0A5, -1, 6'd0);
        idle(3);
        flush("clean_p8");

        prescale = 6'd16; par_en = 1'b1;
        send_frame(9'h03C, -1, 6'd0);
        idle(3);
        flush("parity_ok");
        par_err = 1'b1;
        send_frame(9'h0C3, -1, 6'd0);
        idle(3);
        flush("parity_bad");
        chk("parity_bad_idle", outs(), 0);
        par_err = 1'b0;

        prescale = 6'd8; par_en = 1'b0; strt_glitch = 1'b1;
        s = cyc + 1;
        exp_q.push_back(ev(3, s, 0, 0));
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        #1 chk("glitch_idle", outs(), 0);
        act = 0;
        repeat (10) begin
            @(negedge clk);
            act += int'(dat_samp_en);
        end
        chk("glitch_quiet", act, 0);
        idle(1);
        flush("glitch");
        s = cyc + 1;
        exp_q.push_back(ev(3, s, 0, 0));
        exp_q.push_back(ev(3, s + 9, 0, 0));
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        idle(20);
        flush("glitch_reenter");
        strt_glitch = 1'b0;

        prescale = 6'd8; par_en = 1'b0;
        send_frame(9'h055, -1, 6'd0);
        send_frame(9'h0F0, -1, 6'd0);
        idle(3);
        #1 sp = (dv_t.size() == 2) ? (dv_t[1] - dv_t[0]) : -1;
        chk("b2b_spacing", sp, (DW + 2) * 8);
        flush("b2b");

        stp_err = 1'b1;
        send_frame(9'h081, -1, 6'd0);
        idle(3);
        flush("stop_err");
        stp_err = 1'b0;

        prescale = 6'd8;
        send_frame(9'h07E, 30, 6'd32);
        prescale = 6'd8;
        idle(3);
        flush("prescale_change");
        prescale = 6'd5;
        send_frame(9'h099, -1, 6'd0);
        idle(3);
        flush("prescale_illegal");

        prescale = 6'd8;
        s = cyc + 1;
        exp_q.push_back(ev(3, s, 0, 0));
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_active", int'(dat_samp_en), 1);
        rst = 1'b1;
        #1 chk("reset_mid_data", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        flush("reset_abort");
        send_frame(9'h0B6, -1, 6'd0);
        idle(3);
        flush("post_reset");

        for (int n = 0; n < 10; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0 || n == 0) begin
                idle(gap);
                case ($urandom_range(0, 5))
                    0: prescale = 6'd8;
                    1: prescale = 6'd16;
                    2: prescale = 6'd32;
                    3: prescale = 6'd5;
                    4: prescale = 6'd0;
                    default: prescale = 6'd63;
                endcase
                par_en  = 1'($urandom_range(0, 1));
                stp_err = ($urandom_range(0, 3) == 0);
                par_err = ($urandom_range(0, 2) == 0);
            end
            send_frame(9'($urandom), -1, 6'd0);
        end
        idle(3);
        flush("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
